game_sequencer: RTL and testbench

Central controller for the 2048 game datapath. Decodes keystrokes from the UART receiver and sequences one game turn at a time: move engine, tile spawner, then the board-to-string printer feeding the UART transmitter. Sits between uart_top's rx outputs and the move/spawn/print blocks that share the 320-bit board register. Only one of those blocks is ever active.

---
 rtl/tfe_pkg.sv | 51 +++++
 rtl/game_sequencer_if.sv | 29 ++
 rtl/game_sequencer_key_decoder.sv | 23 ++
 rtl/game_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tfe_pkg.sv
// Shared types and constants for the 2048 game datapath: directions, key codes,
// command encoding and the sequencer state encoding.
package tfe_pkg;

    localparam int BOARD_W = 320;
    localparam int TILE_W  = 20;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam logic [7:0] KEY_W_LO = 8'h77;
    localparam logic [7:0] KEY_W_UP = 8'h57;
    localparam logic [7:0] KEY_S_LO = 8'h73;
    localparam logic [7:0] KEY_S_UP = 8'h53;
    localparam logic [7:0] KEY_A_LO = 8'h61;
    localparam logic [7:0] KEY_A_UP = 8'h41;
    localparam logic [7:0] KEY_D_LO = 8'h64;
    localparam logic [7:0] KEY_D_UP = 8'h44;
    localparam logic [7:0] KEY_R_LO = 8'h72;
    localparam logic [7:0] KEY_R_UP = 8'h52;

    // Bit 2 marks a move; the low two bits then carry the direction code.
    typedef enum logic [2:0] {
        CMD_NONE  = 3'b000,
        CMD_NEW   = 3'b001,
        CMD_UP    = {1'b1, DIR_UP},
        CMD_DOWN  = {1'b1, DIR_DOWN},
        CMD_LEFT  = {1'b1, DIR_LEFT},
        CMD_RIGHT = {1'b1, DIR_RIGHT}
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_WAIT_MOVE,
        ST_CLEAR,
        ST_SPAWN,
        ST_WAIT_SPAWN,
        ST_PRINT,
        ST_WAIT_PRINT
    } state_t;

    function automatic logic is_move(input cmd_t cmd);
        return cmd[2];
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Keystroke input and start/done handshakes between the sequencer and the
// move engine, tile spawner and board printer.
interface game_sequencer_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [1:0] o_move_dir;
    logic       o_move_start;
    logic       i_move_done;
    logic       i_board_changed;
    logic       o_clear_board;
    logic       o_spawn_start;
    logic       i_spawn_done;
    logic       o_print_start;
    logic       i_print_done;

    modport master (
        input  i_rx_data, i_rx_valid, i_move_done, i_board_changed,
               i_spawn_done, i_print_done,
        output o_move_dir, o_move_start, o_clear_board, o_spawn_start,
               o_print_start
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_move_done, i_board_changed,
               i_spawn_done, i_print_done,
        input  o_move_dir, o_move_start, o_clear_board, o_spawn_start,
               o_print_start
    );
endinterface

// File: rtl/game_sequencer_key_decoder.sv
// Combinational keystroke decoder: maps a received ASCII byte to a game command.
module key_decoder
    import tfe_pkg::*;
(
    input  logic [7:0] rx_data,
    output logic       valid,
    output cmd_t       cmd
);

    always_comb begin
        valid = 1'b1;
        cmd   = CMD_NONE;
        case (rx_data)
            KEY_W_LO, KEY_W_UP: cmd = CMD_UP;
            KEY_S_LO, KEY_S_UP: cmd = CMD_DOWN;
            KEY_A_LO, KEY_A_UP: cmd = CMD_LEFT;
            KEY_D_LO, KEY_D_UP: cmd = CMD_RIGHT;
            KEY_R_LO, KEY_R_UP: cmd = CMD_NEW;
            default:            valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/game_sequencer.sv
// Turn sequencer for the 2048 datapath: decodes keys, buffers one command and
// runs move -> spawn -> print, with a per-wait watchdog.
//
// state          | meaning
// ST_IDLE        | waiting for a command (or starting the post-reset game)
// ST_MOVE        | pulse o_move_start
// ST_WAIT_MOVE   | waiting for i_move_done
// ST_CLEAR       | pulse o_clear_board, load new-game spawn count
// ST_SPAWN       | pulse o_spawn_start
// ST_WAIT_SPAWN  | waiting for i_spawn_done
// ST_PRINT       | pulse o_print_start
// ST_WAIT_PRINT  | waiting for i_print_done
module game_sequencer
    import tfe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int NEW_GAME_TILES = 2
) (
    input  logic                clk,
    input  logic                rst,
    game_sequencer_if.master    bus,
    output logic                o_busy,
    output logic [15:0]         o_moves,
    output logic [7:0]          o_dropped,
    output logic                o_fault
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SW = $clog2(NEW_GAME_TILES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t         state, state_n;
    cmd_t           pending, launch, dec_cmd;
    logic           dec_valid, key_valid, pend_valid;
    logic           boot;
    logic [TW-1:0]  timer;
    logic [SW-1:0]  spawn_cnt;
    logic           take_pending, store_key, drop_key, inc_moves, timeout;
    logic           timer_load, spawn_load_new, spawn_load_one, spawn_dec;

    key_decoder u_key_decoder (
        .rx_data (bus.i_rx_data),
        .valid   (dec_valid),
        .cmd     (dec_cmd)
    );

    assign key_valid  = bus.i_rx_valid & dec_valid;
    assign pend_valid = (pending != CMD_NONE);
    assign o_busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n           = state;
        launch            = CMD_NONE;
        take_pending      = 1'b0;
        store_key         = 1'b0;
        drop_key          = 1'b0;
        inc_moves         = 1'b0;
        timeout           = 1'b0;
        timer_load        = 1'b0;
        spawn_load_new    = 1'b0;
        spawn_load_one    = 1'b0;
        spawn_dec         = 1'b0;
        bus.o_move_start  = 1'b0;
        bus.o_clear_board = 1'b0;
        bus.o_spawn_start = 1'b0;
        bus.o_print_start = 1'b0;

        case (state)
            ST_IDLE: begin
                // The first IDLE cycle after reset always starts a new game.
                if (boot) begin
                    state_n = ST_CLEAR;
                end else if (pend_valid) begin
                    launch       = pending;
                    take_pending = 1'b1;
                end else if (key_valid) begin
                    launch = dec_cmd;
                end
                if (launch == CMD_NEW)    state_n = ST_CLEAR;
                else if (is_move(launch)) state_n = ST_MOVE;
            end
            ST_MOVE: begin
                bus.o_move_start = 1'b1;
                timer_load       = 1'b1;
                state_n          = ST_WAIT_MOVE;
            end
            ST_WAIT_MOVE: begin
                if (bus.i_move_done) begin
                    if (bus.i_board_changed) begin
                        inc_moves      = 1'b1;
                        spawn_load_one = 1'b1;
                        state_n        = ST_SPAWN;
                    end else begin
                        state_n = ST_PRINT;
                    end
                end else if (timer == '0) begin
                    timeout = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                bus.o_clear_board = 1'b1;
                spawn_load_new    = 1'b1;
                state_n           = ST_SPAWN;
            end
            ST_SPAWN: begin
                bus.o_spawn_start = 1'b1;
                timer_load        = 1'b1;
                state_n           = ST_WAIT_SPAWN;
            end
            ST_WAIT_SPAWN: begin
                if (bus.i_spawn_done) begin
                    spawn_dec = 1'b1;
                    state_n   = (spawn_cnt <= SW'(1)) ? ST_PRINT : ST_SPAWN;
                end else if (timer == '0) begin
                    timeout = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_PRINT: begin
                bus.o_print_start = 1'b1;
                timer_load        = 1'b1;
                state_n           = ST_WAIT_PRINT;
            end
            ST_WAIT_PRINT: begin
                if (bus.i_print_done) begin
                    state_n = ST_IDLE;
                end else if (timer == '0) begin
                    timeout = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // A key not consumed directly goes into the slot, or is dropped if full.
        if (key_valid && !timeout) begin
            if (take_pending)             store_key = 1'b1;
            else if (launch == CMD_NONE)  begin
                if (pend_valid) drop_key  = 1'b1;
                else            store_key = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            boot           <= 1'b1;
            pending        <= CMD_NONE;
            bus.o_move_dir <= 2'd0;
            o_moves        <= 16'd0;
            o_dropped      <= 8'd0;
            o_fault        <= 1'b0;
            timer          <= '0;
            spawn_cnt      <= '0;
        end else begin
            if (state == ST_IDLE) boot <= 1'b0;

            if (timeout)           pending <= CMD_NONE;
            else if (store_key)    pending <= dec_cmd;
            else if (take_pending) pending <= CMD_NONE;

            if (is_move(launch)) bus.o_move_dir <= launch[1:0];

            if (inc_moves) o_moves <= o_moves + 16'd1;
            if (drop_key && (o_dropped != 8'hFF)) o_dropped <= o_dropped + 8'd1;

            if (timeout)                o_fault <= 1'b1;
            else if (state == ST_CLEAR) o_fault <= 1'b0;

            if (timer_load)        timer <= TIMER_LOAD;
            else if (timer != '0)  timer <= timer - TW'(1);

            if (spawn_load_new)      spawn_cnt <= SW'(NEW_GAME_TILES);
            else if (spawn_load_one) spawn_cnt <= SW'(1);
            else if (spawn_dec)      spawn_cnt <= spawn_cnt - SW'(1);
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: expected start pulses are queued with the
// stimulus and popped by a pulse monitor; a responder acknowledges each start.
module tb_game_sequencer;
    import tfe_pkg::*;

    localparam int TO       = 16;
    localparam int EV_CLEAR = 10;
    localparam int EV_SPAWN = 20;
    localparam int EV_PRINT = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] moves;
    logic [7:0]  dropped;
    logic        fault;

    game_sequencer_if bus();

    game_sequencer #(.TIMEOUT_CYCLES(TO), .NEW_GAME_TILES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .o_busy    (busy),
        .o_moves   (moves),
        .o_dropped (dropped),
        .o_fault   (fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int exp_moves = 0;
    int mv_cnt = 0, sp_cnt = 0, pr_cnt = 0;
    int print_delay = 4;
    bit move_ack_en = 1'b1;
    bit changed_cfg = 1'b1;

    // Downstream block models: acknowledge each start after a fixed delay.
    initial begin
        bus.i_rx_data       = 8'h00;
        bus.i_rx_valid      = 1'b0;
        bus.i_move_done     = 1'b0;
        bus.i_board_changed = 1'b0;
        bus.i_spawn_done    = 1'b0;
        bus.i_print_done    = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_move_done  = 1'b0;
            bus.i_spawn_done = 1'b0;
            bus.i_print_done = 1'b0;
            if (mv_cnt > 0) begin
                mv_cnt--;
                if (mv_cnt == 0) begin
                    bus.i_move_done     = 1'b1;
                    bus.i_board_changed = changed_cfg;
                end
            end
            if (sp_cnt > 0) begin
                sp_cnt--;
                if (sp_cnt == 0) bus.i_spawn_done = 1'b1;
            end
            if (pr_cnt > 0) begin
                pr_cnt--;
                if (pr_cnt == 0) bus.i_print_done = 1'b1;
            end
            if (!rst && bus.o_move_start && move_ack_en) mv_cnt = 3;
            if (!rst && bus.o_spawn_start) sp_cnt = 2;
            if (!rst && bus.o_print_start) pr_cnt = print_delay;
        end
    end

    // Pulse monitor: every start pulse must match the head of the scoreboard.
    initial begin
        int obs, npulse, e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                npulse = int'(bus.o_clear_board) + int'(bus.o_spawn_start) +
                         int'(bus.o_print_start) + int'(bus.o_move_start);
                obs = -1;
                if (bus.o_clear_board) obs = EV_CLEAR;
                if (bus.o_spawn_start) obs = EV_SPAWN;
                if (bus.o_print_start) obs = EV_PRINT;
                if (bus.o_move_start)  obs = int'(bus.o_move_dir);
                if (npulse > 1) begin
                    total++;
                    bad++;
                    $display("FAIL multi_pulse: %0d pulses at once, required at most 1 (t=%0t)", npulse, $time);
                end else if (npulse == 1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_pulse: got event %0d, required none (t=%0t)", obs, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (obs !== e) begin
                            bad++;
                            $display("FAIL pulse_order: got event %0d, required %0d (t=%0t)", obs, e, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish before %0t", $time);
        $fatal(1, "global timeout");
    end

    task automatic push_boot();
        exp_q.push_back(EV_CLEAR);
        exp_q.push_back(EV_SPAWN);
        exp_q.push_back(EV_SPAWN);
        exp_q.push_back(EV_PRINT);
    endtask

    task automatic send_key(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int run = 0;
        int n   = 0;
        while (run < 3 && n < 400) begin
            @(negedge clk);
            n++;
            run = busy ? 0 : run + 1;
        end
        total++;
        if (run < 3) begin
            bad++;
            $display("FAIL %s_idle: busy still %0b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mv_cnt = 0; sp_cnt = 0; pr_cnt = 0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        total += 5;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        if (moves !== 16'd0) begin bad++; $display("FAIL reset_moves: got %0d, required 0", moves); end
        if (dropped !== 8'd0) begin bad++; $display("FAIL reset_dropped: got %0d, required 0", dropped); end
        if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %0b, required 0", fault); end
        if ({bus.o_move_start, bus.o_clear_board, bus.o_spawn_start, bus.o_print_start, bus.o_move_dir} !== 6'd0) begin
            bad++;
            $display("FAIL reset_pulses: got %b, required 000000",
                     {bus.o_move_start, bus.o_clear_board, bus.o_spawn_start, bus.o_print_start, bus.o_move_dir});
        end
        push_boot();
        exp_moves = 0;
        rst = 1'b0;
        wait_idle("reset");
        total += 2;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL reset_events: %0d left, required 0", exp_q.size()); end
        if (moves !== 16'd0) begin bad++; $display("FAIL reset_moves_after: got %0d, required 0", moves); end
    endtask

    task automatic test_move_changed();
        changed_cfg = 1'b1;
        exp_q.push_back(int'(DIR_LEFT));
        exp_q.push_back(EV_SPAWN);
        exp_q.push_back(EV_PRINT);
        bus.i_rx_data  = 8'h61;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        total += 2;
        if (bus.o_move_start !== 1'b1) begin bad++; $display("FAIL move_latency: start=%0b, required 1", bus.o_move_start); end
        if (bus.o_move_dir !== 2'd2) begin bad++; $display("FAIL move_dir_a: got %0d, required 2", bus.o_move_dir); end
        wait_idle("move_changed");
        exp_moves++;
        total += 2;
        if (moves !== 16'(exp_moves)) begin bad++; $display("FAIL move_changed_count: got %0d, required %0d", moves, exp_moves); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL move_changed_events: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_move_unchanged();
        changed_cfg = 1'b0;
        exp_q.push_back(int'(DIR_UP));
        exp_q.push_back(EV_PRINT);
        send_key(8'h57);
        wait_idle("move_unchanged");
        total += 2;
        if (moves !== 16'(exp_moves)) begin bad++; $display("FAIL move_unchanged_count: got %0d, required %0d", moves, exp_moves); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL move_unchanged_events: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_buffer();
        int n = 0;
        changed_cfg = 1'b0;
        print_delay = 10;
        exp_q.push_back(int'(DIR_LEFT));
        exp_q.push_back(EV_PRINT);
        exp_q.push_back(int'(DIR_RIGHT));
        exp_q.push_back(EV_PRINT);
        send_key(8'h61);
        while (!bus.o_print_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.o_print_start !== 1'b1) begin bad++; $display("FAIL buffer_print_wait: start=%0b, required 1", bus.o_print_start); end
        send_key(8'h64);
        send_key(8'h73);
        send_key(8'h78);
        wait_idle("buffer");
        print_delay = 4;
        total += 3;
        if (dropped !== 8'd1) begin bad++; $display("FAIL buffer_dropped: got %0d, required 1", dropped); end
        if (moves !== 16'(exp_moves)) begin bad++; $display("FAIL buffer_moves: got %0d, required %0d", moves, exp_moves); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL buffer_events: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        move_ack_en = 1'b0;
        exp_q.push_back(int'(DIR_DOWN));
        bus.i_rx_data  = 8'h73;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        @(negedge clk);
        repeat (15) @(negedge clk);
        total++;
        if (fault !== 1'b0) begin bad++; $display("FAIL timeout_early: fault=%0b, required 0", fault); end
        @(negedge clk);
        total += 3;
        if (fault !== 1'b1) begin bad++; $display("FAIL timeout_fault: got %0b, required 1", fault); end
        if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle: busy=%0b, required 0", busy); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL timeout_events: %0d left, required 0", exp_q.size()); end
        move_ack_en = 1'b1;
        push_boot();
        send_key(8'h72);
        wait_idle("timeout_clear");
        total += 3;
        if (fault !== 1'b0) begin bad++; $display("FAIL timeout_cleared: fault=%0b, required 0", fault); end
        if (moves !== 16'(exp_moves)) begin bad++; $display("FAIL timeout_moves: got %0d, required %0d", moves, exp_moves); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL timeout_new_events: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_new_game();
        logic [7:0] keys [5] = '{8'h77, 8'h61, 8'h73, 8'h64, 8'h44};
        int         dirs [5] = '{0, 2, 1, 3, 3};
        rst = 1'b1;
        mv_cnt = 0; sp_cnt = 0; pr_cnt = 0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_boot();
        exp_moves = 0;
        rst = 1'b0;
        wait_idle("new_game_reset");
        changed_cfg = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(dirs[i]);
            exp_q.push_back(EV_SPAWN);
            exp_q.push_back(EV_PRINT);
            send_key(keys[i]);
            wait_idle("new_game_move");
            exp_moves++;
        end
        total++;
        if (moves !== 16'd5) begin bad++; $display("FAIL new_game_moves5: got %0d, required 5", moves); end
        push_boot();
        send_key(8'h52);
        wait_idle("new_game_clear");
        total += 3;
        if (moves !== 16'd5) begin bad++; $display("FAIL new_game_moves_kept: got %0d, required 5", moves); end
        if (dropped !== 8'd0) begin bad++; $display("FAIL new_game_dropped: got %0d, required 0", dropped); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL new_game_events: %0d left, required 0", exp_q.size()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_move_changed();
        test_move_unchanged();
        test_buffer();
        test_timeout();
        test_new_game();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
